// File: rtl/reg_cfg_arbiter.sv
// Register-bus arbiter: after reset or Cfg_start, programs the MAC station address
// into the TX (and, with REG_CFG_RX_FILTER_EN defined, RX) PROM via a write table.
module reg_cfg_arbiter (
    input  logic        Clk_reg,
    input  logic        Reset_n,
    input  logic        H_CSB,
    input  logic        H_WRB,
    input  logic [7:0]  H_CA,
    input  logic [15:0] H_CD_in,
    output logic [15:0] H_CD_out,
    output logic        H_wait,
    output logic        CSB,
    output logic        WRB,
    output logic [7:0]  CA,
    output logic [15:0] CD_in,
    input  logic [15:0] CD_out,
    input  logic [47:0] Mac_addr,
    input  logic        Cfg_start,
    output logic        Cfg_busy,
    output logic        Cfg_done
);

    typedef enum logic [1:0] {IDLE, ARM, WR, GAP} state_t;

`ifdef REG_CFG_RX_FILTER_EN
    localparam logic [5:0] LAST_STEP = 6'd49;
`else
    localparam logic [5:0] LAST_STEP = 6'd24;
`endif

    state_t      state_q, state_d;
    logic [5:0]  step_q, step_d;
    logic        done_q, done_d;

    logic        rx_grp;
    logic [4:0]  idx;
    logic [5:0]  rx_off;
    logic [2:0]  byte_i;
    logic [1:0]  phase;
    logic [7:0]  mac_byte;
    logic [6:0]  word;
    logic [15:0] wdata;

    // Steps 0..23 are four writes per MAC byte to the TX PROM; steps 24..47 repeat
    // the same pattern on the RX PROM words when the filter is built in.
    always_comb begin
        rx_grp = 1'b0;
        rx_off = step_q - 6'd24;
        idx    = step_q[4:0];
`ifdef REG_CFG_RX_FILTER_EN
        if (step_q >= 6'd24 && step_q < 6'd48) begin
            rx_grp = 1'b1;
            idx    = rx_off[4:0];
        end
`endif
        byte_i = idx[4:2];
        phase  = idx[1:0];
        case (byte_i)
            3'd0:    mac_byte = Mac_addr[47:40];
            3'd1:    mac_byte = Mac_addr[39:32];
            3'd2:    mac_byte = Mac_addr[31:24];
            3'd3:    mac_byte = Mac_addr[23:16];
            3'd4:    mac_byte = Mac_addr[15:8];
            3'd5:    mac_byte = Mac_addr[7:0];
            default: mac_byte = '0;
        endcase

        word  = '0;
        wdata = '0;
        if (step_q == LAST_STEP) begin
            word  = 7'd7;
            wdata = 16'd1;
        end
`ifdef REG_CFG_RX_FILTER_EN
        else if (step_q == 6'd48) begin
            word  = 7'd14;
            wdata = 16'd1;
        end
`endif
        else begin
            case (phase)
                2'd0: begin
                    word  = rx_grp ? 7'd15 : 7'd8;
                    wdata = {8'h00, mac_byte};
                end
                2'd1: begin
                    word  = rx_grp ? 7'd16 : 7'd9;
                    wdata = {13'd0, byte_i};
                end
                2'd2: begin
                    word  = rx_grp ? 7'd17 : 7'd10;
                    wdata = 16'd1;
                end
                default: begin
                    word  = rx_grp ? 7'd17 : 7'd10;
                    wdata = 16'd0;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        done_d  = done_q;
        CSB     = 1'b1;
        WRB     = 1'b1;
        CA      = '0;
        CD_in   = '0;
        case (state_q)
            IDLE: begin
                CSB   = H_CSB;
                WRB   = H_WRB;
                CA    = H_CA;
                CD_in = H_CD_in;
                if (Cfg_start) begin
                    state_d = ARM;
                    step_d  = '0;
                    done_d  = 1'b0;
                end
            end
            // Wait for the host to drop chip select so its access (and the
            // registered read data one cycle later) is not cut off.
            ARM: begin
                if (H_CSB) begin
                    state_d = WR;
                    step_d  = '0;
                end
            end
            WR: begin
                CSB     = 1'b0;
                WRB     = 1'b0;
                CA      = {word, 1'b0};
                CD_in   = wdata;
                state_d = GAP;
            end
            GAP: begin
                if (step_q == LAST_STEP) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    step_d  = step_q + 6'd1;
                    state_d = WR;
                end
            end
            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge Clk_reg or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ARM;
            step_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    assign Cfg_busy = (state_q != IDLE);
    assign Cfg_done = done_q;
    assign H_wait   = Cfg_busy & ~H_CSB;
    assign H_CD_out = CD_out;

endmodule
